// File: rtl/div_unit_pkg.sv
// div_unit_pkg: opcodes, iteration count and FSM encoding shared by the divider and hazard logic.
package div_unit_pkg;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
    localparam int DIV_ITER = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, FIX = 2'd2} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration on {rem,quo} against an unsigned divisor.
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor};
    // trial[WIDTH] is the borrow: set means the divisor did not fit
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU for the EX stage; restoring division on magnitudes,
// sign fix-up in FIX, result packed as {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(parameter int WIDTH = 32) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [7:0]         alucontrol,
    input  logic               start,
    input  logic               annul,
    output logic               busy,
    output logic               result_ok,
    output logic [2*WIDTH-1:0] result
);
    div_state_t state, state_next;
    logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
    logic [5:0] cnt;
    logic qsign, rsign, dz, sgn, go, last;
    assign sgn  = alucontrol == EXE_DIV_OP;
    assign go   = state == IDLE && start && !annul && (sgn || alucontrol == EXE_DIVU_OP);
    assign last = cnt == 6'(DIV_ITER - 1);
    assign busy = state != IDLE;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem), .quo(quo), .divisor(dvs), .rem_next(rem_n), .quo_next(quo_n)
    );
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    always_comb begin
        state_next = state;
        state_next = annul ? IDLE :
                     state == IDLE   ? (go ? DIVIDE : IDLE) :
                     state == DIVIDE ? (last ? FIX : DIVIDE) : IDLE;
    end
    // Dividend magnitude lives in quo and shifts into rem one bit per iteration
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            qsign     <= 1'b0;
            rsign     <= 1'b0;
            dz        <= 1'b0;
            result_ok <= 1'b0;
            result    <= '0;
        end else begin
            result_ok <= 1'b0;
            if (go) begin
                rem   <= '0;
                quo   <= sgn && a[WIDTH-1] ? -a : a;
                dvs   <= sgn && b[WIDTH-1] ? -b : b;
                qsign <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                rsign <= sgn && a[WIDTH-1];
                dz    <= b == '0;
                cnt   <= '0;
            end else if (state == DIVIDE && !annul) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 6'd1;
            end else if (state == FIX && !annul) begin
                // on divide-by-zero rem holds |a|, so re-applying the dividend sign restores a
                result    <= {rsign ? -rem : rem, qsign && !dz ? -quo : quo};
                result_ok <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed DIV/DIVU vectors checked against literals and a countdown reference model.
module tb_div_unit;
    import div_unit_pkg::*;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [7:0]  alucontrol = '0;
    logic        start = 1'b0, annul = 1'b0;
    logic        busy, result_ok;
    logic [63:0] result;
    int checks = 0, failures = 0;

    div_unit dut (
        .clk(clk), .resetn(resetn), .a(a), .b(b), .alucontrol(alucontrol),
        .start(start), .annul(annul), .busy(busy), .result_ok(result_ok), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (op == EXE_DIVU_OP) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: an accepted op completes 33 edges later unless annulled
    logic        m_busy = 1'b0, m_ok = 1'b0;
    logic [63:0] m_res = '0, m_pend = '0;
    int          m_left = 0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_ok   <= 1'b0;
            m_res  <= '0;
            m_left <= 0;
        end else begin
            m_ok <= 1'b0;
            if (m_busy) begin
                if (annul) m_busy <= 1'b0;
                else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_ok   <= 1'b1;
                    m_res  <= m_pend;
                end
                m_left <= m_left - 1;
            end else if (start && !annul && (alucontrol == EXE_DIV_OP || alucontrol == EXE_DIVU_OP)) begin
                m_busy <= 1'b1;
                m_left <= 33;
                m_pend <= ref_div(alucontrol, a, b);
            end
        end
    end

    always @(negedge clk) begin
        check("model_busy", {63'd0, busy}, {63'd0, m_busy});
        check("model_ok", {63'd0, result_ok}, {63'd0, m_ok});
        check("model_result", result, m_res);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
        alucontrol = op;
        a = x;
        b = y;
        start = 1'b1;
        cyc();
        start = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0003;
        alucontrol = 8'h00;
    endtask

    task automatic wait_ok(output int n);
        n = 1;
        while (!result_ok && n < 60) begin
            cyc();
            n++;
        end
    endtask

    task automatic run(input string name, input logic [7:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp);
        int n;
        check({name, "_ref"}, ref_div(op, x, y), exp);
        launch(op, x, y);
        check({name, "_busy"}, {63'd0, busy}, 64'd1);
        wait_ok(n);
        check({name, "_latency"}, 64'(n), 64'd34);
        check({name, "_result"}, result, exp);
        check({name, "_busy_at_ok"}, {63'd0, busy}, 64'd0);
        cyc();
        check({name, "_ok_pulse"}, {63'd0, result_ok}, 64'd0);
    endtask

    initial begin
        int n;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ok", {63'd0, result_ok}, 64'd0);
        check("reset_result", result, 64'd0);
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
        alucontrol = 8'h00;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("bad_op_ignored", {63'd0, busy}, 64'd0);
        run("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 64'h00000002_0000000E);
        run("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
        run("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        run("divu_ovf", EXE_DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000);
        run("divu_dz", EXE_DIVU_OP, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
        run("div_dz", EXE_DIV_OP, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
        run("div_dz_neg", EXE_DIV_OP, 32'hFFFF_FFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF);
        // annul mid-division, with an ignored start while busy
        launch(EXE_DIVU_OP, 32'd100, 32'd7);
        repeat (3) cyc();
        alucontrol = EXE_DIVU_OP;
        a = 32'd9;
        b = 32'd4;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        annul = 1'b1;
        cyc();
        annul = 1'b0;
        check("annul_busy_drop", {63'd0, busy}, 64'd0);
        check("annul_result_held", result, 64'hFFFFFFF0_FFFFFFFF);
        alucontrol = EXE_DIVU_OP;
        start = 1'b1;
        annul = 1'b1;
        cyc();
        start = 1'b0;
        annul = 1'b0;
        check("annul_beats_start", {63'd0, busy}, 64'd0);
        run("divu_9_4", EXE_DIVU_OP, 32'd9, 32'd4, 64'h00000001_00000002);
        // asynchronous reset mid-division
        launch(EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7);
        repeat (14) cyc();
        #2;
        resetn = 1'b0;
        #1;
        check("areset_busy", {63'd0, busy}, 64'd0);
        check("areset_ok", {63'd0, result_ok}, 64'd0);
        check("areset_result", result, 64'd0);
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
        run("post_reset_divu", EXE_DIVU_OP, 32'd100, 32'd7, 64'h00000002_0000000E);
        wait_ok(n);
        check("no_spurious_ok", {63'd0, result_ok}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
